// File: rtl/skyhop_pkg.sv
// Shared constants and types for the skyhop map pipeline.
package skyhop_pkg;

  // Columns per generated layer; bit 0 is the leftmost column.
  localparam int unsigned LAYER_W = 7;

  // Default number of layers held on screen (power of 2).
  localparam int unsigned DEPTH_DEFAULT = 8;

  localparam logic [LAYER_W-1:0] LAYER_ZERO = '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_READY,
    S_WAIT
  } sched_state_e;

endpackage

// File: rtl/layer_ring_buf.sv
// DEPTH x (2*LAYER_W) register file: one synchronous write port, one
// registered read port, every entry cleared synchronously on rst.
module layer_ring_buf
  import skyhop_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [LAYER_W-1:0]       wr_layer,
  input  logic [LAYER_W-1:0]       wr_type,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [LAYER_W-1:0]       rd_layer,
  output logic [LAYER_W-1:0]       rd_type
);

  // Each entry packs {type, occupancy}.
  logic [2*LAYER_W-1:0] mem_q [DEPTH];

  // Storage: clear everything on reset, otherwise single write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
    end else if (wr_en) begin
      mem_q[wr_addr] <= {wr_type, wr_layer};
    end
  end

  // Registered read; a same-cycle write is not forwarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_layer <= '0;
      rd_type  <= '0;
    end else begin
      {rd_type, rd_layer} <= mem_q[rd_addr];
    end
  end

endmodule

// File: rtl/map_layer_scheduler.sv
// Sequences the layer generator and owns the on-screen map as a ring buffer.
// Optional build macro PLAYABLE_CHECK_EN: replaces an unreachable new top layer
// with the previous top layer and exposes a saturating fixup_cnt.
module map_layer_scheduler
  import skyhop_pkg::*;
#(
  parameter int unsigned DEPTH       = DEPTH_DEFAULT,
  parameter int unsigned INIT_LAYERS = 4,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     scroll_req,
  output logic                     gen_map,
  input  logic [LAYER_W-1:0]       layer_in,
  input  logic [LAYER_W-1:0]       type_in,
  input  logic                     layer_valid,
  input  logic [$clog2(DEPTH)-1:0] rd_row,
  output logic [LAYER_W-1:0]       rd_layer,
  output logic [LAYER_W-1:0]       rd_type,
  output logic                     map_ready,
  output logic                     scroll_done,
  output logic                     timeout_err,
  output logic                     scroll_drop
`ifdef PLAYABLE_CHECK_EN
  ,
  output logic [7:0]               fixup_cnt
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned FW = $clog2(DEPTH + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  sched_state_e state_q, state_d;

  logic [AW-1:0] base_q;
  logic [FW-1:0] fill_cnt_q;
  logic [TW-1:0] tmo_q;
  logic          pending_q;
  logic          gen_map_q, map_ready_q, scroll_done_q, scroll_drop_q, timeout_err_q;

  logic               busy, tmo_hit, beat, full;
  logic               launch_fill, launch_scroll, fill_last, wait_done;
  logic [AW-1:0]      top_row, wr_row, wr_addr, rd_addr;
  logic [LAYER_W-1:0] wr_layer, wr_type;

`ifdef PLAYABLE_CHECK_EN
  logic [LAYER_W-1:0] prev_layer_q, prev_type_q, reach;
  logic [7:0]         fixup_cnt_q;
  logic               fixup;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (launch_fill)   state_d = S_FILL;
      S_FILL:  if (fill_last)     state_d = S_READY;
      S_READY: if (launch_scroll) state_d = S_WAIT;
      S_WAIT:  if (wait_done)     state_d = S_READY;
      default:                    state_d = S_IDLE;
    endcase
  end

  // FSM decoded controls and write-port selection.
  always_comb begin
    busy          = (state_q == S_FILL) || (state_q == S_WAIT);
    // Data arriving in the timeout cycle takes precedence over substitution.
    tmo_hit       = busy && !layer_valid && (tmo_q == TW'(TIMEOUT_CYC - 1));
    beat          = busy && (layer_valid || tmo_hit);
    launch_fill   = (state_q == S_IDLE) && start;
    launch_scroll = (state_q == S_READY) && (scroll_req || pending_q);
    fill_last     = (state_q == S_FILL) && beat && (fill_cnt_q == FW'(INIT_LAYERS - 1));
    wait_done     = (state_q == S_WAIT) && beat;
    full          = (fill_cnt_q == FW'(DEPTH));
    // fill_cnt was already bumped when a pre-full scroll launched.
    top_row       = full ? AW'(DEPTH - 1) : AW'(fill_cnt_q - 1'b1);
    wr_row        = (state_q == S_FILL) ? fill_cnt_q[AW-1:0] : top_row;
    wr_addr       = base_q + wr_row;
    wr_layer      = layer_valid ? layer_in : LAYER_ZERO;
    wr_type       = layer_valid ? type_in : LAYER_ZERO;
`ifdef PLAYABLE_CHECK_EN
    // A layer is reachable if it touches the previous top column or a neighbour.
    reach = prev_layer_q | (prev_layer_q << 1) | (prev_layer_q >> 1);
    fixup = busy && layer_valid && !((state_q == S_FILL) && (fill_cnt_q == '0)) &&
            ((layer_in & reach) == LAYER_ZERO);
    if (fixup) begin
      wr_layer = prev_layer_q;
      wr_type  = prev_type_q;
    end
`endif
  end

  // Pointers, timeout counter, pending request and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      base_q        <= '0;
      fill_cnt_q    <= '0;
      tmo_q         <= '0;
      pending_q     <= 1'b0;
      gen_map_q     <= 1'b0;
      map_ready_q   <= 1'b0;
      scroll_done_q <= 1'b0;
      scroll_drop_q <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      gen_map_q     <= launch_fill || launch_scroll;
      scroll_done_q <= wait_done;
      scroll_drop_q <= busy && scroll_req && pending_q;
      timeout_err_q <= timeout_err_q || tmo_hit;

      if (fill_last || wait_done) map_ready_q <= 1'b1;
      else if (launch_scroll)     map_ready_q <= 1'b0;

      // A fresh request arriving as the pending one launches stays queued.
      if (launch_scroll)           pending_q <= pending_q && scroll_req;
      else if (busy && scroll_req) pending_q <= 1'b1;

      if (launch_fill || launch_scroll || beat) tmo_q <= '0;
      else if (busy)                            tmo_q <= tmo_q + 1'b1;

      if (((state_q == S_FILL) && beat) || (launch_scroll && !full)) begin
        fill_cnt_q <= fill_cnt_q + 1'b1;
      end
      if (launch_scroll && full) base_q <= base_q + 1'b1;
    end
  end

`ifdef PLAYABLE_CHECK_EN
  // Track the last written top layer and count substitutions.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_layer_q <= '0;
      prev_type_q  <= '0;
      fixup_cnt_q  <= '0;
    end else begin
      if (beat) begin
        prev_layer_q <= wr_layer;
        prev_type_q  <= wr_type;
      end
      if (fixup && (fixup_cnt_q != 8'hff)) fixup_cnt_q <= fixup_cnt_q + 1'b1;
    end
  end

  assign fixup_cnt = fixup_cnt_q;
`endif

  assign rd_addr     = base_q + rd_row;
  assign gen_map     = gen_map_q;
  assign map_ready   = map_ready_q;
  assign scroll_done = scroll_done_q;
  assign scroll_drop = scroll_drop_q;
  assign timeout_err = timeout_err_q;

  layer_ring_buf #(
    .DEPTH (DEPTH)
  ) u_ring (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (beat),
    .wr_addr  (wr_addr),
    .wr_layer (wr_layer),
    .wr_type  (wr_type),
    .rd_addr  (rd_addr),
    .rd_layer (rd_layer),
    .rd_type  (rd_type)
  );

endmodule

// File: tb/tb_map_layer_scheduler.sv
// Self-checking bench for map_layer_scheduler: table-driven fill/scroll vectors,
// a logical row model and a read scoreboard, plus hand-written corner sequences.
module tb_map_layer_scheduler;

  logic       clk = 1'b0;
  logic       rst, start, scroll_req, gen_map, layer_valid;
  logic [6:0] layer_in, type_in, rd_layer, rd_type;
  logic [2:0] rd_row;
  logic       map_ready, scroll_done, timeout_err, scroll_drop;
`ifdef PLAYABLE_CHECK_EN
  logic [7:0] fixup_cnt;
`endif

  map_layer_scheduler #(
    .DEPTH       (8),
    .INIT_LAYERS (4),
    .TIMEOUT_CYC (255)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .scroll_req  (scroll_req),
    .gen_map     (gen_map),
    .layer_in    (layer_in),
    .type_in     (type_in),
    .layer_valid (layer_valid),
    .rd_row      (rd_row),
    .rd_layer    (rd_layer),
    .rd_type     (rd_type),
    .map_ready   (map_ready),
    .scroll_done (scroll_done),
    .timeout_err (timeout_err),
    .scroll_drop (scroll_drop)
`ifdef PLAYABLE_CHECK_EN
    ,
    .fixup_cnt   (fixup_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Pulse counters sampled on the falling edge.
  int   gen_cnt = 0, consec_cnt = 0, done_cnt = 0, drop_cnt = 0;
  logic gen_prev = 1'b0;
  always @(negedge clk) begin
    if (gen_map) gen_cnt <= gen_cnt + 1;
    if (gen_map && gen_prev) consec_cnt <= consec_cnt + 1;
    if (scroll_done) done_cnt <= done_cnt + 1;
    if (scroll_drop) drop_cnt <= drop_cnt + 1;
    gen_prev <= gen_map;
  end

  typedef struct {
    logic [6:0] layer;
    logic [6:0] typ;
    int         gap;
    logic       exp_ready;
    logic [2:0] exp_row;
  } vec_t;

  typedef struct packed {
    logic [6:0] l;
    logic [6:0] t;
    int         row;
  } rd_exp_t;

  vec_t    fill_tbl[4];
  vec_t    scr_tbl[5];
  rd_exp_t sb[$];

  // Logical view of the screen: index 0 is the bottom row.
  logic [6:0] m_layer[8];
  logic [6:0] m_type[8];
  int         m_fill;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      m_layer[i] = '0;
      m_type[i]  = '0;
    end
    m_fill = 0;
  endtask

  task automatic model_push(input logic [6:0] l, input logic [6:0] t);
    if (m_fill < 8) begin
      m_layer[m_fill] = l;
      m_type[m_fill]  = t;
      m_fill++;
    end else begin
      for (int i = 0; i < 7; i++) begin
        m_layer[i] = m_layer[i+1];
        m_type[i]  = m_type[i+1];
      end
      m_layer[7] = l;
      m_type[7]  = t;
    end
  endtask

  task automatic beat(input logic [6:0] l, input logic [6:0] t);
    layer_valid = 1'b1;
    layer_in    = l;
    type_in     = t;
    step();
    layer_valid = 1'b0;
    layer_in    = '0;
    type_in     = '0;
  endtask

  task automatic wait_gen(input string name);
    int n = 0;
    while (gen_map !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk(name, gen_map, 1);
  endtask

  task automatic read_row(input int r, input logic [6:0] el, input logic [6:0] et,
                          input string tag);
    rd_exp_t e;
    rd_row = 3'(r);
    sb.push_back('{l: el, t: et, row: r});
    step();
    e = sb.pop_front();
    chk($sformatf("%s_row%0d_layer", tag, e.row), rd_layer, e.l);
    chk($sformatf("%s_row%0d_type", tag, e.row), rd_type, e.t);
  endtask

  task automatic read_all(input string tag);
    for (int r = 0; r < 8; r++) read_row(r, m_layer[r], m_type[r], tag);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_gen_map"}, gen_map, 0);
    chk({tag, "_map_ready"}, map_ready, 0);
    chk({tag, "_scroll_done"}, scroll_done, 0);
    chk({tag, "_timeout_err"}, timeout_err, 0);
    chk({tag, "_scroll_drop"}, scroll_drop, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int g0, d0, p0, n;

    fill_tbl[0] = '{layer: 7'b0001000, typ: 7'h11, gap: 0, exp_ready: 1'b0, exp_row: 3'd0};
    fill_tbl[1] = '{layer: 7'b1010101, typ: 7'h22, gap: 2, exp_ready: 1'b0, exp_row: 3'd1};
    fill_tbl[2] = '{layer: 7'b0101010, typ: 7'h33, gap: 0, exp_ready: 1'b0, exp_row: 3'd2};
    fill_tbl[3] = '{layer: 7'b1010101, typ: 7'h44, gap: 1, exp_ready: 1'b1, exp_row: 3'd3};
    scr_tbl[0]  = '{layer: 7'b1110000, typ: 7'h51, gap: 0, exp_ready: 1'b1, exp_row: 3'd4};
    scr_tbl[1]  = '{layer: 7'b1110000, typ: 7'h52, gap: 1, exp_ready: 1'b1, exp_row: 3'd5};
    scr_tbl[2]  = '{layer: 7'b1110000, typ: 7'h53, gap: 3, exp_ready: 1'b1, exp_row: 3'd6};
    scr_tbl[3]  = '{layer: 7'b1110000, typ: 7'h54, gap: 0, exp_ready: 1'b1, exp_row: 3'd7};
    scr_tbl[4]  = '{layer: 7'b1110000, typ: 7'h55, gap: 2, exp_ready: 1'b1, exp_row: 3'd7};

    rst = 1'b1; start = 1'b0; scroll_req = 1'b0; layer_valid = 1'b0;
    layer_in = '0; type_in = '0; rd_row = '0;
    model_clear();
    repeat (3) step();
    chk_outputs_zero("reset");
    chk("reset_rd_layer", rd_layer, 0);
    chk("reset_rd_type", rd_type, 0);
    rst = 1'b0;
    read_all("rst");

    // Initial fill.
    g0 = gen_cnt;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("fill_gen", gen_map, 1);
    chk("fill_not_ready", map_ready, 0);
    for (int i = 0; i < 4; i++) begin
      repeat (fill_tbl[i].gap) step();
      beat(fill_tbl[i].layer, fill_tbl[i].typ);
      model_push(fill_tbl[i].layer, fill_tbl[i].typ);
      chk($sformatf("fill%0d_ready", i), map_ready, fill_tbl[i].exp_ready);
    end
    step();
    chk("fill_gen_once", gen_cnt - g0, 1);
`ifdef PLAYABLE_CHECK_EN
    chk("fill_fixup", fixup_cnt, 0);
`endif
    read_all("fill");

    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_ignored", gen_map, 0);

    // Scrolls: four appends, then one that moves base.
    d0 = done_cnt;
    for (int i = 0; i < 5; i++) begin
      scroll_req = 1'b1;
      step();
      scroll_req = 1'b0;
      chk($sformatf("scr%0d_gen", i), gen_map, 1);
      chk($sformatf("scr%0d_busy", i), map_ready, 0);
      repeat (scr_tbl[i].gap) step();
      beat(scr_tbl[i].layer, scr_tbl[i].typ);
      model_push(scr_tbl[i].layer, scr_tbl[i].typ);
      chk($sformatf("scr%0d_done", i), scroll_done, 1);
      chk($sformatf("scr%0d_ready", i), map_ready, scr_tbl[i].exp_ready);
      read_row(scr_tbl[i].exp_row, scr_tbl[i].layer, scr_tbl[i].typ, $sformatf("scr%0d", i));
    end
    step();
    chk("scr_done_count", done_cnt - d0, 5);
    read_row(7, 7'b1110000, 7'h55, "scr_top");
    read_row(0, 7'b1010101, 7'h22, "scr_bottom");
    read_all("scroll");

    // Three back-to-back requests: one launches, one pends, one drops.
    d0 = done_cnt; p0 = drop_cnt; g0 = gen_cnt;
    scroll_req = 1'b1;
    repeat (3) step();
    scroll_req = 1'b0;
    chk("busy_drop_pulse", scroll_drop, 1);
    beat(7'b1110000, 7'h61);
    model_push(7'b1110000, 7'h61);
    chk("busy_done1", scroll_done, 1);
    wait_gen("busy_pending_gen");
    beat(7'b1110000, 7'h62);
    model_push(7'b1110000, 7'h62);
    chk("busy_done2", scroll_done, 1);
    step();
    step();
    chk("busy_drop_count", drop_cnt - p0, 1);
    chk("busy_done_count", done_cnt - d0, 2);
    chk("busy_gen_count", gen_cnt - g0, 2);
    read_all("busy");

    // Valid beat in the 255th waiting cycle beats the timeout.
    d0 = done_cnt;
    scroll_req = 1'b1;
    step();
    scroll_req = 1'b0;
    repeat (254) step();
    chk("late_no_done_yet", scroll_done, 0);
    beat(7'b0111000, 7'h70);
    model_push(7'b0111000, 7'h70);
    chk("late_done", scroll_done, 1);
    chk("late_no_tmo", timeout_err, 0);
    read_row(7, 7'b0111000, 7'h70, "late");
    chk("late_done_count", done_cnt - d0, 1);

    // No data at all: zeros substituted after 255 cycles.
    scroll_req = 1'b1;
    step();
    scroll_req = 1'b0;
    n = 0;
    while (scroll_done !== 1'b1 && n < 300) begin
      step();
      n++;
    end
    chk("tmo_latency", n, 255);
    chk("tmo_err", timeout_err, 1);
    chk("tmo_ready", map_ready, 1);
    model_push(7'b0000000, 7'b0000000);
    read_all("tmo");

    // Reset in the middle of a wait.
    scroll_req = 1'b1;
    step();
    scroll_req = 1'b0;
    step();
    chk("tmo_sticky", timeout_err, 1);
    g0 = gen_cnt;
    rst = 1'b1;
    step();
    chk_outputs_zero("midrst");
    step();
    rst = 1'b0;
    model_clear();
    read_all("midrst");
    beat(7'b1111111, 7'b1111111);
    scroll_req = 1'b1;
    step();
    scroll_req = 1'b0;
    repeat (10) step();
    chk("idle_no_gen", gen_cnt - g0, 0);
    chk("idle_not_ready", map_ready, 0);
    read_row(0, 7'b0000000, 7'b0000000, "idle_ignored");

`ifdef PLAYABLE_CHECK_EN
    start = 1'b1;
    step();
    start = 1'b0;
    beat(7'b0001000, 7'h01);
    beat(7'b1000001, 7'h02);
    chk("play_fixup1", fixup_cnt, 1);
    beat(7'b0000100, 7'h03);
    chk("play_fixup_kept", fixup_cnt, 1);
    beat(7'b0001000, 7'h04);
    read_row(0, 7'b0001000, 7'h01, "play");
    read_row(1, 7'b0001000, 7'h01, "play");
    read_row(2, 7'b0000100, 7'h03, "play");
    read_row(3, 7'b0001000, 7'h04, "play");
`endif

    step();
    chk("gen_never_back_to_back", consec_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
